lms_weight_update: RTL and testbench
====================================

Name: lms_weight_update

Overview:
- Downstream companion of the 16-tap serial adaptive FIR stage.
- Consumes the error word `e` and the 16 reference taps that produced it.
- Performs one LMS coefficient update per error sample, w_k <- sat(w_k + ((e * x_k) >>> MU_SHIFT)), serially, one tap per clock.
- Drives the 16 32-bit weights back into the FIR stage's weight_in ports.

Parameters:
- NTAPS, 16, number of taps/weights (counter and bus sizing follow it).
- REF_W, 14, width of each reference sample.
- W_W, 32, width of each weight and of the error word.
- MU_SHIFT, 10, step size mu = 2^-MU_SHIFT, applied as an arithmetic right shift.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, active-low, synchronous.
- adap_filter_state  input  1  adaptation enable; low aborts/blocks updates.
- weight_clear  input  1  synchronous clear of all weights to 0.
- e_in  input  W_W  error word, signed two's complement.
- e_valid  input  1  single-cycle strobe: e_in and ref_bus are valid.
- ref_bus  input  NTAPS*REF_W  packed taps, signed; tap k at [REF_W*k+REF_W-1 : REF_W*k].
- weight_bus  output  NTAPS*W_W  packed weights, signed; weight k at [W_W*k+W_W-1 : W_W*k].
- busy  output  1  high while an update sweep is in progress.
- update_done  output  1  one-cycle pulse after the last tap is written.
- overrun  output  1  sticky: an e_valid was dropped.

Behaviour:
- Reset is synchronous: rstn=0 at a rising edge sets every output to 0.
  - Weights, busy, update_done, overrun, state=IDLE, idx=0.
  - Applies mid-sweep too; the partial sweep is discarded, with no done pulse.
- Priority at each edge: rstn > weight_clear > adap_filter_state abort > normal operation.
- weight_clear=1:
  - All weights go to 0, state goes to IDLE, busy=0, no update_done.
  - overrun is cleared as well.
- FSM, two states.
  - IDLE: on e_valid=1 and adap_filter_state=1:
    - Latch e_in into e_reg and ref_bus into ref_reg (a snapshot; later input changes are ignored).
    - idx<=0, busy<=1, go to UPDATE.
    - e_valid with adap_filter_state=0 is ignored and does not set overrun.
  - UPDATE: each edge updates weight[idx] using e_reg and ref_reg[idx], then idx<=idx+1.
    - At idx=NTAPS-1 the edge writes the last weight, sets update_done<=1, busy<=0, state<=IDLE, idx<=0.
  - adap_filter_state=0 during UPDATE:
    - At that edge no weight is written, state goes to IDLE, busy<=0, no update_done.
    - Weights already written keep their new values.
- Latency: e_valid accepted at edge T.
  - Taps 0..15 are written at edges T+1..T+16.
  - update_done is high for the cycle after T+16 and is cleared at T+17.
  - Next acceptance is possible at edge T+17.
- e_valid=1 at any edge where state=UPDATE (including T+16) is dropped and sets overrun=1.
  - overrun stays set until reset or weight_clear.
- Arithmetic:
  - Product p = signed(e_reg) * signed(ref_reg[idx]), full 46-bit signed.
  - delta = p >>> MU_SHIFT (arithmetic, floor toward -inf).
  - sum = weight + delta, computed at 47 bits.
  - Result saturates to [-2^31, 2^31-1]; it never wraps.
- weight_bus is driven directly from the weight registers, with no output pipeline.
- Weights not indexed in a given cycle hold their value.

Test Plan:
- Reset: hold rstn=0 for 2 edges after random activity -> weight_bus=0, busy=0, update_done=0, overrun=0.
- Basic sweep: MU_SHIFT=10, all weights 0, e_in=1024, all taps=+1, single e_valid -> busy high for 16 cycles, every weight=1, one update_done pulse at T+17 cycle.
- Signs/floor: e_in=-2048, tap3=-5, tap4=+3, other taps 0 -> w3=+10, w4=-6, others 0. Then e_in=-1, tap0=+1 -> w0 decreases by 1 (floor of -1/1024 = -1).
- Saturation: preload w7=0x7FFFFFF0 via prior sweeps, e_in=2^20, tap7=8191 -> w7=0x7FFFFFFF. Mirror case with tap7=-8192 from 0x80000010 -> w7=0x80000000.
- Abort and overrun:
  - Drop adap_filter_state after taps 0..4 are written -> taps 5..15 unchanged, no update_done.
  - Separately, pulse e_valid at T+8 -> overrun=1, sweep result unaffected, overrun holds until weight_clear.
- Mid-sweep reset/clear: rstn=0 at T+9 -> all zero next cycle. weight_clear at T+9 -> weights 0, busy 0, a new e_valid accepted at the following edge.

Source files
------------

// File: rtl/lms_weight_update.sv
// Serial LMS coefficient update: one tap per clock, w_k <- sat(w_k + ((e*x_k) >>> MU_SHIFT)).
// Ports: clk, rstn (sync active-low), adap_filter_state, weight_clear, e_in/e_valid/ref_bus in;
//        weight_bus (packed weights), busy, update_done, overrun out.
module lms_weight_update #(
    parameter int NTAPS    = 16,
    parameter int REF_W    = 14,
    parameter int W_W      = 32,
    parameter int MU_SHIFT = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   adap_filter_state,
    input  logic                   weight_clear,
    input  logic [W_W-1:0]         e_in,
    input  logic                   e_valid,
    input  logic [NTAPS*REF_W-1:0] ref_bus,
    output logic [NTAPS*W_W-1:0]   weight_bus,
    output logic                   busy,
    output logic                   update_done,
    output logic                   overrun
);

    localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int P_W   = W_W + REF_W;
    localparam int S_W   = P_W + 1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

    localparam logic signed [S_W-1:0] SAT_HI =
        {{(S_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] SAT_LO =
        {{(S_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic signed [W_W-1:0]   e_reg;
    logic [NTAPS*REF_W-1:0]  ref_reg;
    logic signed [W_W-1:0]   weights [NTAPS];

    logic signed [REF_W-1:0] cur_ref;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   delta;
    logic signed [S_W-1:0]   sum;
    logic signed [W_W-1:0]   new_w;

    // Datapath for the tap currently addressed by idx.
    always_comb begin
        cur_ref = ref_reg[idx*REF_W +: REF_W];
        prod    = P_W'(e_reg) * P_W'(cur_ref);
        delta   = prod >>> MU_SHIFT;
        sum     = S_W'(weights[idx]) + S_W'(delta);
        if (sum > SAT_HI) begin
            new_w = SAT_HI[W_W-1:0];
        end else if (sum < SAT_LO) begin
            new_w = SAT_LO[W_W-1:0];
        end else begin
            new_w = sum[W_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= '0;
            e_reg       <= '0;
            ref_reg     <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < NTAPS; k++) weights[k] <= '0;
        end else if (weight_clear) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < NTAPS; k++) weights[k] <= '0;
        end else begin
            update_done <= 1'b0;
            // Any strobe arriving mid-sweep is lost; remember that it happened.
            if (state == UPDATE && e_valid) overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (e_valid && adap_filter_state) begin
                        e_reg   <= e_in;
                        ref_reg <= ref_bus;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (!adap_filter_state) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        weights[idx] <= new_w;
                        if (idx == LAST) begin
                            update_done <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                            idx         <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_bus
        assign weight_bus[k*W_W +: W_W] = weights[k];
    end

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update: scoreboard of expected weight vectors
// popped on each update_done, plus per-scenario inline checks.
module tb_lms_weight_update;

    localparam int NTAPS    = 16;
    localparam int REF_W    = 14;
    localparam int W_W      = 32;
    localparam int MU_SHIFT = 10;
    localparam int BUS      = NTAPS * W_W;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   adap_filter_state;
    logic                   weight_clear;
    logic [W_W-1:0]         e_in;
    logic                   e_valid;
    logic [NTAPS*REF_W-1:0] ref_bus;
    logic [BUS-1:0]         weight_bus;
    logic                   busy;
    logic                   update_done;
    logic                   overrun;

    int checks = 0;
    int errors = 0;

    longint         mw  [NTAPS];
    int             tap [NTAPS];
    logic [BUS-1:0] sb_q[$];

    always #5 clk = ~clk;

    lms_weight_update #(
        .NTAPS(NTAPS), .REF_W(REF_W), .W_W(W_W), .MU_SHIFT(MU_SHIFT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .adap_filter_state(adap_filter_state),
        .weight_clear(weight_clear),
        .e_in(e_in),
        .e_valid(e_valid),
        .ref_bus(ref_bus),
        .weight_bus(weight_bus),
        .busy(busy),
        .update_done(update_done),
        .overrun(overrun)
    );

    function automatic longint sat(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference model: apply the update to taps lo..hi.
    function automatic void model(longint e, int lo, int hi);
        for (int k = lo; k <= hi; k++) begin
            longint p;
            longint d;
            p = e * longint'(tap[k]);
            d = p >>> MU_SHIFT;
            mw[k] = sat(mw[k] + d);
        end
    endfunction

    function automatic logic [BUS-1:0] model_bus();
        logic [BUS-1:0] b;
        longint v;
        b = '0;
        for (int k = 0; k < NTAPS; k++) begin
            v = mw[k];
            b[k*W_W +: W_W] = v[W_W-1:0];
        end
        return b;
    endfunction

    function automatic logic [NTAPS*REF_W-1:0] ref_pack();
        logic [NTAPS*REF_W-1:0] r;
        int t;
        r = '0;
        for (int k = 0; k < NTAPS; k++) begin
            t = tap[k];
            r[k*REF_W +: REF_W] = t[REF_W-1:0];
        end
        return r;
    endfunction

    function automatic void zero_model();
        for (int k = 0; k < NTAPS; k++) mw[k] = 0;
    endfunction

    function automatic void zero_taps();
        for (int k = 0; k < NTAPS; k++) tap[k] = 0;
    endfunction

    function automatic void rand_taps();
        for (int k = 0; k < NTAPS; k++)
            tap[k] = int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic longint rand_e();
        return longint'($urandom_range(0, 33554431)) - 64'sd16777216;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    // Inputs are scrambled afterwards so the snapshot is exercised.
    task automatic drive_ev(longint e);
        e_in              = e[W_W-1:0];
        ref_bus           = ref_pack();
        e_valid           = 1'b1;
        adap_filter_state = 1'b1;
        @(negedge clk);
        e_valid = 1'b0;
        e_in    = $urandom;
        ref_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic sweep_push(longint e);
        model(e, 0, NTAPS - 1);
        sb_q.push_back(model_bus());
        drive_ev(e);
    endtask

    // Entered at negedge n0 after acceptance; returns at the negedge where done is seen.
    task automatic wait_done(string name, int n0);
        int n;
        int bh;
        logic [BUS-1:0] exp;
        n  = n0;
        bh = n0 - 1;
        checks++;
        if (update_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_early got %b want 0", name, update_done);
        end
        while (update_done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bh++;
            @(negedge clk);
            n++;
        end
        exp = sb_q.pop_front();
        checks++;
        if (update_done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout got no update_done want pulse", name);
        end else begin
            checks++;
            if (n != 17) begin
                errors++;
                $display("FAIL %s latency got %0d want 17", name, n);
            end
            checks++;
            if (bh != 16 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy got %0d cycles (now %b) want 16 (now 0)",
                         name, bh, busy);
            end
            checks++;
            if (weight_bus !== exp) begin
                errors++;
                $display("FAIL %s weights got %h want %h", name, weight_bus, exp);
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        weight_clear = 1'b1;
        @(negedge clk);
        weight_clear = 1'b0;
        zero_model();
    endtask

    task automatic test_reset();
        rstn              = 1'b0;
        adap_filter_state = 1'b0;
        weight_clear      = 1'b0;
        e_valid           = 1'b0;
        e_in              = '0;
        ref_bus           = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rand_taps();
        drive_ev(rand_e());
        repeat (5) @(negedge clk);
        e_valid = 1'b1;
        @(negedge clk);
        e_valid = 1'b0;
        rstn    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (weight_bus !== '0 || busy !== 1'b0 || update_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset got w=%h busy=%b done=%b ovr=%b want all 0",
                     weight_bus, busy, update_done, overrun);
        end
        rstn = 1'b1;
        zero_model();
    endtask

    task automatic test_basic();
        for (int k = 0; k < NTAPS; k++) tap[k] = 1;
        @(negedge clk);
        sweep_push(1024);
        wait_done("basic", 1);
        checks++;
        if (weight_bus[15*W_W +: W_W] !== 32'd1) begin
            errors++;
            $display("FAIL basic_w15 got %h want 00000001", weight_bus[15*W_W +: W_W]);
        end
    endtask

    task automatic test_signs_floor();
        do_clear();
        zero_taps();
        tap[3] = -5;
        tap[4] = 3;
        sweep_push(-2048);
        wait_done("signs", 1);
        checks++;
        if (weight_bus[3*W_W +: W_W] !== 32'd10 || weight_bus[4*W_W +: W_W] !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL signs_w3w4 got %h %h want 0000000a fffffffa",
                     weight_bus[3*W_W +: W_W], weight_bus[4*W_W +: W_W]);
        end
        zero_taps();
        tap[0] = 1;
        @(negedge clk);
        sweep_push(-1);
        wait_done("floor", 1);
        checks++;
        if (weight_bus[0 +: W_W] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL floor_w0 got %h want ffffffff", weight_bus[0 +: W_W]);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        zero_taps();
        tap[7] = 1024;
        sweep_push(64'sd2147483632);
        wait_done("sat_pre_hi", 1);
        tap[7] = 8191;
        @(negedge clk);
        sweep_push(64'sd1048576);
        wait_done("sat_hi", 1);
        checks++;
        if (weight_bus[7*W_W +: W_W] !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL sat_hi_w7 got %h want 7fffffff", weight_bus[7*W_W +: W_W]);
        end
        do_clear();
        tap[7] = 1024;
        sweep_push(-64'sd2147483632);
        wait_done("sat_pre_lo", 1);
        tap[7] = -8192;
        @(negedge clk);
        sweep_push(64'sd1048576);
        wait_done("sat_lo", 1);
        checks++;
        if (weight_bus[7*W_W +: W_W] !== 32'h80000000) begin
            errors++;
            $display("FAIL sat_lo_w7 got %h want 80000000", weight_bus[7*W_W +: W_W]);
        end
    endtask

    task automatic test_abort();
        longint e;
        int seen;
        do_clear();
        rand_taps();
        e = rand_e();
        model(e, 0, 4);
        drive_ev(e);
        repeat (5) @(negedge clk);
        adap_filter_state = 1'b0;
        @(negedge clk);
        seen = 0;
        checks++;
        if (busy !== 1'b0 || weight_bus !== model_bus()) begin
            errors++;
            $display("FAIL abort got busy=%b w=%h want busy=0 w=%h",
                     busy, weight_bus, model_bus());
        end
        repeat (15) begin
            if (update_done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || weight_bus !== model_bus()) begin
            errors++;
            $display("FAIL abort_hold got done=%0d w=%h want done=0 w=%h",
                     seen, weight_bus, model_bus());
        end
        adap_filter_state = 1'b1;
    endtask

    task automatic test_overrun();
        do_clear();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_init got %b want 0", overrun);
        end
        rand_taps();
        sweep_push(rand_e());
        repeat (7) @(negedge clk);
        e_in    = 32'h12345678;
        ref_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        e_valid = 1'b1;
        @(negedge clk);
        e_valid = 1'b0;
        wait_done("ovr_sweep", 9);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b want 1", overrun);
        end
        rand_taps();
        @(negedge clk);
        sweep_push(rand_e());
        wait_done("ovr_second", 1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b want 1", overrun);
        end
        do_clear();
        checks++;
        if (overrun !== 1'b0 || weight_bus !== '0) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%b w=%h want 0", overrun, weight_bus);
        end
    endtask

    task automatic test_back_to_back();
        rand_taps();
        @(negedge clk);
        sweep_push(rand_e());
        wait_done("b2b_first", 1);
        rand_taps();
        sweep_push(rand_e());
        wait_done("b2b_second", 1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        rand_taps();
        @(negedge clk);
        drive_ev(rand_e());
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        zero_model();
        checks++;
        if (weight_bus !== '0 || busy !== 1'b0 || update_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got w=%h busy=%b done=%b ovr=%b want all 0",
                     weight_bus, busy, update_done, overrun);
        end
        seen = 0;
        repeat (12) begin
            if (update_done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_mid_clear();
        rand_taps();
        @(negedge clk);
        drive_ev(rand_e());
        repeat (8) @(negedge clk);
        weight_clear = 1'b1;
        @(negedge clk);
        weight_clear = 1'b0;
        zero_model();
        checks++;
        if (weight_bus !== '0 || busy !== 1'b0 || update_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear got w=%h busy=%b done=%b want 0",
                     weight_bus, busy, update_done);
        end
        rand_taps();
        sweep_push(rand_e());
        wait_done("mid_clear_next", 1);
    endtask

    initial begin
        zero_model();
        zero_taps();
        test_reset();
        test_basic();
        test_signs_floor();
        test_saturation();
        test_abort();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_mid_clear();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
